// File: rtl/aes_round_sequencer_pkg.sv
// Shared AES types, sequencer FSM encoding and the GF(2^8) byte layers used by the round datapath.
package aes_round_sequencer_pkg;

   typedef logic [15:0][7:0] state_t;
   typedef logic [127:0]     roundKey_t;

   localparam int NR_128 = 10;
   localparam int NR_192 = 12;
   localparam int NR_256 = 14;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} seqState_t;

   // AES byte i (column-major, byte 0 first on the wire) sits in the most significant slice.
   function automatic logic [3:0] bidx(input int i);
      return 4'(15 - i);
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse computed as a^254, which also maps 0 to 0.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] sq;
      r  = 8'h01;
      sq = a;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   function automatic state_t sub_bytes(input state_t s, input logic inv);
      state_t r;
      for (int i = 0; i < 16; i++)
         r[bidx(i)] = inv ? inv_sbox(s[bidx(i)]) : sbox(s[bidx(i)]);
      return r;
   endfunction

   function automatic state_t shift_rows(input state_t s, input logic inv);
      state_t r;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++)
            r[bidx(4 * c + row)] = s[bidx(4 * ((inv ? c - row + 4 : c + row) % 4) + row)];
      return r;
   endfunction

   function automatic state_t mix_columns(input state_t s, input logic inv);
      state_t      r;
      logic [31:0] k;
      k = inv ? 32'h0e0b0d09 : 32'h02030101;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++)
            r[bidx(4 * c + row)] = gmul(s[bidx(4 * c + row)], k[31:24])
                                 ^ gmul(s[bidx(4 * c + (row + 1) % 4)], k[23:16])
                                 ^ gmul(s[bidx(4 * c + (row + 2) % 4)], k[15:8])
                                 ^ gmul(s[bidx(4 * c + (row + 3) % 4)], k[7:0]);
      return r;
   endfunction

endpackage

// File: rtl/aes_round_datapath.sv
// Combinational AES round; decrypt selects the inverse layer order, finalRound drops (Inv)MixColumns.
module aes_round_datapath
   import aes_round_sequencer_pkg::*;
(
   input  state_t    state,
   input  roundKey_t roundKey,
   input  logic      decrypt,
   input  logic      finalRound,
   output state_t    nextState
);

   state_t enc_sr;
   state_t dec_ark;

   always_comb begin
      enc_sr  = shift_rows(sub_bytes(state, 1'b0), 1'b0);
      dec_ark = sub_bytes(shift_rows(state, 1'b1), 1'b1) ^ roundKey;
      if (decrypt)
         nextState = finalRound ? dec_ark : mix_columns(dec_ark, 1'b1);
      else
         nextState = (finalRound ? enc_sr : mix_columns(enc_sr, 1'b0)) ^ roundKey;
   end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES controller: whitening on accept, then one shared round per clock until NR rounds are done.
module aes_round_sequencer
   import aes_round_sequencer_pkg::*;
#(
   parameter int NR          = NR_128,
   parameter int KEY_INDEX_W = 4
)(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   inValid,
   output logic                   inReady,
   input  state_t                 inState,
   input  logic                   inDecrypt,
   output logic [KEY_INDEX_W-1:0] keyIndex,
   input  roundKey_t              roundKey,
   output logic                   outValid,
   input  logic                   outReady,
   output state_t                 outState,
   output logic                   busy
);

   localparam logic [KEY_INDEX_W-1:0] NR_IDX = KEY_INDEX_W'(NR);

   seqState_t              fsm_p0;
   logic [KEY_INDEX_W-1:0] cnt_p0;
   state_t                 blk_p0;
   logic                   dec_p0;
   state_t                 round_out;
   logic                   final_round;
   logic                   accept;

   if (2 ** KEY_INDEX_W <= NR) begin : g_bad_index_w
      $error("KEY_INDEX_W cannot address round key NR");
   end

   aes_round_datapath u_datapath (
      .state      (blk_p0),
      .roundKey   (roundKey),
      .decrypt    (dec_p0),
      .finalRound (final_round),
      .nextState  (round_out)
   );

   always_comb begin
      inReady     = (fsm_p0 == IDLE) || ((fsm_p0 == DONE) && outReady);
      accept      = inValid && inReady;
      final_round = (cnt_p0 == NR_IDX);
      // Outside ROUND the key store points at the whitening key for whichever block may arrive.
      if (fsm_p0 == ROUND)
         keyIndex = dec_p0 ? NR_IDX - cnt_p0 : cnt_p0;
      else
         keyIndex = inDecrypt ? NR_IDX : '0;
   end

   assign outValid = (fsm_p0 == DONE);
   assign busy     = (fsm_p0 == ROUND);
   assign outState = blk_p0;

   always_ff @(posedge clock) begin
      if (reset) begin
         fsm_p0 <= IDLE;
         cnt_p0 <= '0;
         blk_p0 <= '0;
         dec_p0 <= 1'b0;
      end else begin
         case (fsm_p0)
            ROUND: begin
               blk_p0 <= round_out;
               if (final_round) fsm_p0 <= DONE;
               else             cnt_p0 <= cnt_p0 + 1'b1;
            end
            default: begin
               // DONE with a same-cycle accept hands straight over to the next block.
               if (accept) begin
                  blk_p0 <= inState ^ roundKey;
                  dec_p0 <= inDecrypt;
                  cnt_p0 <= KEY_INDEX_W'(1);
                  fsm_p0 <= ROUND;
               end else if (fsm_p0 == DONE && outReady) begin
                  fsm_p0 <= IDLE;
               end
            end
         endcase
      end
   end

   a_instate_known: assert property (@(posedge clock) disable iff (reset)
      inValid |-> !$isunknown(inState));
   a_roundkey_known: assert property (@(posedge clock) disable iff (reset)
      (fsm_p0 == ROUND || (fsm_p0 == IDLE && inValid)) |-> !$isunknown(roundKey));
   a_keyindex_range: assert property (@(posedge clock) disable iff (reset)
      keyIndex <= NR_IDX);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench: FIPS-197 C.1 vectors on an NR=10 instance and C.3 on an NR=14 instance.
module tb_aes_round_sequencer;
   import aes_round_sequencer_pkg::*;

   localparam int NRA = NR_128;
   localparam int NRB = NR_256;
   localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT3    = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic         clock = 1'b0;
   logic         reset;
   logic         inValid_a, inReady_a, inDecrypt_a, outValid_a, outReady_a, busy_a;
   logic [127:0] inState_a, roundKey_a, outState_a;
   logic [3:0]   keyIndex_a;
   logic         inValid_b, inReady_b, inDecrypt_b, outValid_b, outReady_b, busy_b;
   logic [127:0] inState_b, roundKey_b, outState_b;
   logic [3:0]   keyIndex_b;

   logic [127:0] rk_a [16];
   logic [127:0] rk_b [16];
   logic [31:0]  w [60];
   logic [7:0]   sb [256];
   logic [127:0] exp_a [$];
   logic [127:0] exp_b [$];
   int           total = 0;
   int           bad = 0;

   always #5 clock = ~clock;

   assign roundKey_a = rk_a[keyIndex_a];
   assign roundKey_b = rk_b[keyIndex_b];

   aes_round_sequencer #(.NR(NRA), .KEY_INDEX_W(4)) dut_a (
      .clock(clock), .reset(reset), .inValid(inValid_a), .inReady(inReady_a),
      .inState(inState_a), .inDecrypt(inDecrypt_a), .keyIndex(keyIndex_a),
      .roundKey(roundKey_a), .outValid(outValid_a), .outReady(outReady_a),
      .outState(outState_a), .busy(busy_a)
   );

   aes_round_sequencer #(.NR(NRB), .KEY_INDEX_W(4)) dut_b (
      .clock(clock), .reset(reset), .inValid(inValid_b), .inReady(inReady_b),
      .inState(inState_b), .inDecrypt(inDecrypt_b), .keyIndex(keyIndex_b),
      .roundKey(roundKey_b), .outValid(outValid_b), .outReady(outReady_b),
      .outState(outState_b), .busy(busy_b)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // S-box from exp/log tables over generator 3.
   task automatic build_sbox();
      logic [7:0] ex [256];
      logic [7:0] lg [256];
      logic [7:0] e;
      logic [7:0] v;
      e = 8'h01;
      for (int i = 0; i < 255; i++) begin
         ex[i] = e;
         lg[e] = 8'(i);
         e = e ^ xt(e);
      end
      for (int a = 0; a < 256; a++) begin
         v = (a == 0) ? 8'h00 : ex[(255 - int'(lg[a])) % 255];
         sb[a] = v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
   endfunction

   task automatic expand(input logic [255:0] key, input int nk, input int nr);
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) begin
         w[i] = key[255:224];
         key  = key << 32;
      end
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
   endtask

   task automatic drive_a(input logic [127:0] blk, input logic dec, input logic [127:0] want,
                          input logic keep);
      int n;
      n = 0;
      inValid_a   = 1'b1;
      inState_a   = blk;
      inDecrypt_a = dec;
      @(negedge clock);
      while (!inReady_a && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) chk("a_in_timeout", 128'(inReady_a), 128'(1));
      chk("a_kidx_whiten", 128'(keyIndex_a), dec ? 128'(NRA) : 128'(0));
      if (keep) exp_a.push_back(want);
      @(posedge clock);
      #1;
      inValid_a = 1'b0;
   endtask

   // Counts edges from the accept edge (as 1) to the edge that raises outValid.
   task automatic wait_out_a(output int lat);
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
         if (lat == 1) chk("a_busy_after_accept", 128'(busy_a), 128'(1));
      end while (!outValid_a && lat < 100);
      if (!outValid_a) chk("a_out_timeout", 128'(outValid_a), 128'(1));
   endtask

   always @(negedge clock) begin
      if (!reset && outValid_a && outReady_a) begin
         chk("a_sb_pending", 128'(exp_a.size() != 0), 128'(1));
         if (exp_a.size() != 0) chk("a_out", outState_a, exp_a.pop_front());
      end
      if (!reset && outValid_b && outReady_b) begin
         chk("b_sb_pending", 128'(exp_b.size() != 0), 128'(1));
         if (exp_b.size() != 0) chk("b_out", outState_b, exp_b.pop_front());
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   initial begin
      int lat;
      reset = 1'b1;
      inValid_a = 1'b0; inState_a = '0; inDecrypt_a = 1'b0; outReady_a = 1'b1;
      inValid_b = 1'b0; inState_b = '0; inDecrypt_b = 1'b0; outReady_b = 1'b1;
      build_sbox();
      for (int k = 0; k < 16; k++) begin
         rk_a[k] = '0;
         rk_b[k] = '0;
      end
      expand({KEY128, 128'h0}, 4, NRA);
      for (int k = 0; k <= NRA; k++) rk_a[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
      expand(KEY256, 8, NRB);
      for (int k = 0; k <= NRB; k++) rk_b[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};

      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_inReady", 128'(inReady_a), 128'(1));
      chk("rst_outValid", 128'(outValid_a), 128'(0));
      chk("rst_busy", 128'(busy_a), 128'(0));
      chk("rst_outState", outState_a, 128'(0));
      chk("rst_keyIndex", 128'(keyIndex_a), 128'(0));
      @(posedge clock);
      #1;

      // C.1 encrypt
      drive_a(PT, 1'b0, CT1, 1'b1);
      wait_out_a(lat);
      chk("a_enc_latency", 128'(lat), 128'(NRA + 1));
      @(posedge clock);
      #1;

      // C.1 decrypt with key index walk
      drive_a(CT1, 1'b1, PT, 1'b1);
      for (int i = 1; i <= NRA; i++) begin
         @(negedge clock);
         chk("a_dec_kidx", 128'(keyIndex_a), 128'(NRA - i));
      end
      @(negedge clock);
      chk("a_dec_outValid", 128'(outValid_a), 128'(1));
      @(posedge clock);
      #1;

      // Backpressure, then same-cycle handoff to a decrypt block
      outReady_a = 1'b0;
      drive_a(PT, 1'b0, CT1, 1'b1);
      wait_out_a(lat);
      chk("a_bp_latency", 128'(lat), 128'(NRA + 1));
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("a_bp_outValid", 128'(outValid_a), 128'(1));
         chk("a_bp_outState", outState_a, CT1);
         chk("a_bp_inReady", 128'(inReady_a), 128'(0));
      end
      @(posedge clock);
      #1;
      outReady_a = 1'b1;
      drive_a(CT1, 1'b1, PT, 1'b1);
      wait_out_a(lat);
      chk("a_handoff_latency", 128'(lat), 128'(NRA + 1));
      @(posedge clock);
      #1;

      // Reset at round 4 discards the block
      drive_a(PT, 1'b0, CT1, 1'b0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("abort_outValid", 128'(outValid_a), 128'(0));
      chk("abort_inReady", 128'(inReady_a), 128'(1));
      chk("abort_busy", 128'(busy_a), 128'(0));
      chk("abort_outState", outState_a, 128'(0));
      @(posedge clock);
      #1;
      drive_a(PT, 1'b0, CT1, 1'b1);
      wait_out_a(lat);
      chk("a_post_abort_latency", 128'(lat), 128'(NRA + 1));
      @(posedge clock);
      #1;

      // Input churn during ROUND must not disturb the latched block or mode
      drive_a(PT, 1'b0, CT1, 1'b1);
      fork
         wait_out_a(lat);
         begin
            repeat (6) begin
               inValid_a   = 1'b1;
               inDecrypt_a = ~inDecrypt_a;
               inState_a   = {$urandom, $urandom, $urandom, $urandom};
               @(posedge clock);
               #1;
            end
            inValid_a = 1'b0;
         end
      join
      chk("a_churn_latency", 128'(lat), 128'(NRA + 1));
      @(posedge clock);
      #1;

      // C.3 on the NR=14 instance, encrypt then decrypt
      for (int v = 0; v < 2; v++) begin
         inValid_b   = 1'b1;
         inDecrypt_b = v[0];
         inState_b   = (v == 0) ? PT : CT3;
         exp_b.push_back((v == 0) ? CT3 : PT);
         @(negedge clock);
         chk("b_inReady", 128'(inReady_b), 128'(1));
         chk("b_kidx_whiten", 128'(keyIndex_b), (v == 0) ? 128'(0) : 128'(NRB));
         @(posedge clock);
         #1;
         inValid_b = 1'b0;
         lat = 0;
         do begin
            @(negedge clock);
            lat++;
         end while (!outValid_b && lat < 100);
         chk("b_latency", 128'(lat), 128'(NRB + 1));
         @(posedge clock);
         #1;
      end

      repeat (3) @(posedge clock);
      #1;
      chk("a_sb_drained", 128'(exp_a.size()), 128'(0));
      chk("b_sb_drained", 128'(exp_b.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
